// File: rtl/split_rr_bus_arbiter.sv
// Split-transaction bus arbiter: slave split completions beat masters, masters by
// fixed priority or round-robin; each tenure is supervised via the shared bus_util line.
module split_rr_bus_arbiter #(
    parameter int unsigned N_MASTERS     = 12,
    parameter int unsigned N_SLAVES      = 6,
    parameter int unsigned MID_WIDTH     = 4,
    parameter int unsigned MODE          = 0,
    parameter int unsigned START_TIMEOUT = 16,
    parameter int unsigned HOLD_BITS     = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_MASTERS-1:0] m_reqs,
    input  logic [N_SLAVES-1:0]  slaves_in,
    input  logic                 bus_util,
    output logic [N_MASTERS-1:0] m_grants,
    output logic [N_SLAVES-1:0]  slaves_out,
    output logic [MID_WIDTH-1:0] mid_current,
    output logic                 owner_is_slave,
    output logic [3:0]           state,
    output logic                 timeout
);

    localparam int unsigned PTR_W   = 4;
    localparam int unsigned START_W = $clog2(START_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_BUSY    = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [N_MASTERS-1:0] m_grants_q, m_grants_d;
    logic [N_SLAVES-1:0]  slaves_out_q, slaves_out_d;
    logic [MID_WIDTH-1:0] mid_q, mid_d;
    logic                 owner_slave_q, owner_slave_d;
    logic                 timeout_q, timeout_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [START_W-1:0]   start_cnt_q, start_cnt_d;
    logic [HOLD_BITS-1:0] hold_cnt_q, hold_cnt_d;

    logic                 slv_any, m_any, m_hi_any;
    logic [MID_WIDTH-1:0] slv_idx, m_lo, m_hi, m_win;
    logic                 owner_req;

    // Winner search; round-robin takes the first requester above the pointer, else wraps to the lowest.
    always_comb begin
        slv_any  = 1'b0;
        slv_idx  = '0;
        m_any    = 1'b0;
        m_lo     = '0;
        m_hi_any = 1'b0;
        m_hi     = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (slaves_in[i] && !slv_any) begin
                slv_any = 1'b1;
                slv_idx = MID_WIDTH'(i);
            end
        end
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (m_reqs[i]) begin
                if (!m_any) begin
                    m_any = 1'b1;
                    m_lo  = MID_WIDTH'(i);
                end
                if (!m_hi_any && (i > 32'(ptr_q))) begin
                    m_hi_any = 1'b1;
                    m_hi     = MID_WIDTH'(i);
                end
            end
        end
        m_win = ((MODE == 1) && m_hi_any) ? m_hi : m_lo;
    end

    // The held grant vector selects the owner's request line.
    assign owner_req = (|(m_grants_q & m_reqs)) | (|(slaves_out_q & slaves_in));

    always_comb begin
        state_d       = state_q;
        m_grants_d    = m_grants_q;
        slaves_out_d  = slaves_out_q;
        mid_d         = mid_q;
        owner_slave_d = owner_slave_q;
        timeout_d     = 1'b0;
        ptr_d         = ptr_q;
        start_cnt_d   = start_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (slv_any) begin
                    slaves_out_d  = N_SLAVES'(1) << slv_idx;
                    m_grants_d    = '0;
                    mid_d         = slv_idx;
                    owner_slave_d = 1'b1;
                    start_cnt_d   = '0;
                    state_d       = S_GRANT;
                end else if (m_any) begin
                    m_grants_d    = N_MASTERS'(1) << m_win;
                    slaves_out_d  = '0;
                    mid_d         = m_win;
                    owner_slave_d = 1'b0;
                    ptr_d         = PTR_W'(m_win);
                    start_cnt_d   = '0;
                    state_d       = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!bus_util) begin
                    hold_cnt_d = '0;
                    state_d    = S_BUSY;
                end else if (!owner_req) begin
                    m_grants_d   = '0;
                    slaves_out_d = '0;
                    state_d      = S_RELEASE;
                end else if (start_cnt_q == START_W'(START_TIMEOUT - 1)) begin
                    m_grants_d   = '0;
                    slaves_out_d = '0;
                    timeout_d    = 1'b1;
                    state_d      = S_RELEASE;
                end else begin
                    start_cnt_d = start_cnt_q + START_W'(1);
                end
            end
            S_BUSY: begin
                if (bus_util) begin
                    m_grants_d   = '0;
                    slaves_out_d = '0;
                    state_d      = S_RELEASE;
                end else if (&hold_cnt_q) begin
                    m_grants_d   = '0;
                    slaves_out_d = '0;
                    timeout_d    = 1'b1;
                    state_d      = S_RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_BITS'(1);
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                m_grants_d   = '0;
                slaves_out_d = '0;
                state_d      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            m_grants_q    <= '0;
            slaves_out_q  <= '0;
            mid_q         <= '0;
            owner_slave_q <= 1'b0;
            timeout_q     <= 1'b0;
            ptr_q         <= '0;
            start_cnt_q   <= '0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            m_grants_q    <= m_grants_d;
            slaves_out_q  <= slaves_out_d;
            mid_q         <= mid_d;
            owner_slave_q <= owner_slave_d;
            timeout_q     <= timeout_d;
            ptr_q         <= ptr_d;
            start_cnt_q   <= start_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign m_grants       = m_grants_q;
    assign slaves_out     = slaves_out_q;
    assign mid_current    = mid_q;
    assign owner_is_slave = owner_slave_q;
    assign state          = 4'(state_q);
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_split_rr_bus_arbiter.sv
// Directed bench: a fixed-priority instance (default hold) and a round-robin instance
// with a 4-bit tenure counter, each driven by its own request/bus_util stimulus.
module tb_split_rr_bus_arbiter;

    logic        clk = 1'b0;
    logic        rstn;

    logic [11:0] fp_reqs, rr_reqs;
    logic [5:0]  fp_sl, rr_sl;
    logic        fp_util, rr_util;
    logic [11:0] fp_mg, rr_mg;
    logic [5:0]  fp_so, rr_so;
    logic [3:0]  fp_mid, rr_mid;
    logic        fp_ois, rr_ois;
    logic [3:0]  fp_st, rr_st;
    logic        fp_to, rr_to;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    split_rr_bus_arbiter #(.MODE(0)) dut_fp (
        .clk(clk), .rstn(rstn), .m_reqs(fp_reqs), .slaves_in(fp_sl), .bus_util(fp_util),
        .m_grants(fp_mg), .slaves_out(fp_so), .mid_current(fp_mid),
        .owner_is_slave(fp_ois), .state(fp_st), .timeout(fp_to)
    );

    split_rr_bus_arbiter #(.MODE(1), .HOLD_BITS(4)) dut_rr (
        .clk(clk), .rstn(rstn), .m_reqs(rr_reqs), .slaves_in(rr_sl), .bus_util(rr_util),
        .m_grants(rr_mg), .slaves_out(rr_so), .mid_current(rr_mid),
        .owner_is_slave(rr_ois), .state(rr_st), .timeout(rr_to)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait (bounded) for a round-robin grant, check its owner, then run a bus tenure.
    task automatic rr_tenure(input int exp_idx, input int busy);
        int n = 0;
        while (rr_mg == '0 && n < 10) begin
            tick();
            n++;
        end
        check("rr_grant_seen", 32'(rr_mg != '0), 32'd1);
        check("rr_owner", 32'(rr_mid), 32'(exp_idx));
        check("rr_onehot", 32'(rr_mg), 32'(1) << exp_idx);
        rr_util = 1'b0;
        repeat (busy) tick();
        rr_util = 1'b1;
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        fp_reqs = '0; fp_sl = '0; fp_util = 1'b1;
        rr_reqs = '0; rr_sl = '0; rr_util = 1'b1;
        @(negedge clk);
        tick();
        tick();
        check("rst_fp_mg", 32'(fp_mg), 32'h0);
        check("rst_fp_state", 32'(fp_st), 32'd0);
        check("rst_rr_so", 32'(rr_so), 32'h0);
        check("rst_rr_mid", 32'(rr_mid), 32'd0);
        check("rst_rr_timeout", 32'(rr_to), 32'd0);
        rstn = 1'b1;

        // Fixed priority: 0x014 grants master 2, then master 4 after the tenure.
        fp_reqs = 12'h014;
        tick();
        check("fp_grant", 32'(fp_mg), 32'h004);
        check("fp_mid", 32'(fp_mid), 32'd2);
        check("fp_state_grant", 32'(fp_st), 32'd1);
        fp_util = 1'b0;
        repeat (20) tick();
        check("fp_state_busy", 32'(fp_st), 32'd2);
        check("fp_busy_grant", 32'(fp_mg), 32'h004);
        fp_util = 1'b1;
        fp_reqs = 12'h010;
        tick();
        check("fp_release_state", 32'(fp_st), 32'd3);
        check("fp_release_mg", 32'(fp_mg), 32'h0);
        check("fp_release_to", 32'(fp_to), 32'd0);
        check("fp_release_mid", 32'(fp_mid), 32'd2);
        tick();
        check("fp_idle_state", 32'(fp_st), 32'd0);
        check("fp_idle_mg", 32'(fp_mg), 32'h0);
        tick();
        check("fp_second_grant", 32'(fp_mg), 32'h010);
        check("fp_second_mid", 32'(fp_mid), 32'd4);
        fp_reqs = '0;
        tick();
        check("fp_drop_release", 32'(fp_st), 32'd3);
        check("fp_drop_no_to", 32'(fp_to), 32'd0);
        tick();

        // Split request beats a master request.
        fp_sl = 6'h08;
        fp_reqs = 12'h001;
        tick();
        check("split_so", 32'(fp_so), 32'h08);
        check("split_ois", 32'(fp_ois), 32'd1);
        check("split_mid", 32'(fp_mid), 32'd3);
        check("split_mg", 32'(fp_mg), 32'h0);
        fp_sl = '0;
        fp_reqs = '0;
        tick();
        check("split_release_so", 32'(fp_so), 32'h0);
        check("split_hold_ois", 32'(fp_ois), 32'd1);
        tick();

        // Start timeout: grant exactly 16 cycles, timeout in first RELEASE cycle.
        fp_reqs = 12'h010;
        tick();
        for (int k = 0; k < 16; k++) begin
            check($sformatf("st_grant_%0d", k), 32'(fp_mg), 32'h010);
            tick();
        end
        check("st_dropped", 32'(fp_mg), 32'h0);
        check("st_timeout", 32'(fp_to), 32'd1);
        check("st_release", 32'(fp_st), 32'd3);
        tick();
        check("st_idle", 32'(fp_st), 32'd0);
        check("st_to_clear", 32'(fp_to), 32'd0);
        fp_reqs = '0;
        tick();
        check("st_stay_idle", 32'(fp_st), 32'd0);

        // bus_util low and request drop together: BUSY wins.
        fp_reqs = 12'h001;
        tick();
        fp_util = 1'b0;
        fp_reqs = '0;
        tick();
        check("tie_busy", 32'(fp_st), 32'd2);
        fp_util = 1'b1;
        tick();
        check("tie_release", 32'(fp_st), 32'd3);
        check("tie_no_to", 32'(fp_to), 32'd0);

        // Round-robin: 2,4,2,4,2 then add master 11 -> 4,11,2.
        rr_reqs = 12'h014;
        rr_tenure(2, 5);
        rr_tenure(4, 5);
        rr_tenure(2, 5);
        rr_tenure(4, 5);
        rr_tenure(2, 5);
        rr_reqs = 12'h814;
        rr_tenure(4, 5);
        rr_tenure(11, 5);
        rr_reqs = 12'h004;
        rr_tenure(2, 5);
        rr_reqs = '0;
        tick();
        tick();

        // Hold timeout with a 4-bit tenure counter: 16 BUSY cycles.
        rr_reqs = 12'h020;
        tick();
        check("hold_grant", 32'(rr_mg), 32'h020);
        rr_util = 1'b0;
        tick();
        for (int k = 0; k < 16; k++) begin
            check($sformatf("hold_busy_%0d", k), 32'(rr_st), 32'd2);
            tick();
        end
        check("hold_release", 32'(rr_st), 32'd3);
        check("hold_timeout", 32'(rr_to), 32'd1);
        check("hold_dropped", 32'(rr_mg), 32'h0);
        rr_reqs = '0;
        tick();
        check("hold_to_clear", 32'(rr_to), 32'd0);
        rr_util = 1'b1;
        tick();

        // Reset mid-tenure, then pointer restarts at 0: 0x003 grants master 1.
        rr_reqs = 12'h010;
        tick();
        check("rst_pre_grant", 32'(rr_mg), 32'h010);
        rr_util = 1'b0;
        tick();
        check("rst_pre_busy", 32'(rr_st), 32'd2);
        rstn = 1'b0;
        rr_reqs = '0;
        tick();
        check("rst_busy_state", 32'(rr_st), 32'd0);
        check("rst_busy_mg", 32'(rr_mg), 32'h0);
        check("rst_busy_mid", 32'(rr_mid), 32'd0);
        check("rst_busy_ois", 32'(rr_ois), 32'd0);
        check("rst_busy_to", 32'(rr_to), 32'd0);
        rstn = 1'b1;
        rr_util = 1'b1;
        rr_reqs = 12'h003;
        tick();
        check("rst_rr_mid1", 32'(rr_mid), 32'd1);
        check("rst_rr_grant1", 32'(rr_mg), 32'h002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
